byte_adder_sched: RTL and testbench

Multi-cycle shared adder controller for the two-core RV32 pipeline. It arbitrates between two requesters, one per core, using round-robin. It latches the granted 32-bit operands and sequences a single 8-bit prefix-adder slice over WIDTH/8 byte passes, chaining the carry between passes. It returns sum, carry-out and signed overflow to the requester that issued the operation.

---
 rtl/byte_adder_sched.sv | 162 ++++++++++++++++
 tb/tb_byte_adder_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_adder_sched.sv
// byte_adder_sched
//   Shared multi-cycle adder for two requesters. A round-robin arbiter picks
//   one operation, latches its operands and runs one 8-bit prefix-adder slice
//   over WIDTH/8 byte passes, chaining the carry. The result is returned with
//   a one-cycle pulse on the owning core's response valid.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   reqN_valid/ready/a/b/sub         request handshake and operands (N = 0,1)
//   rspN_valid                       one-cycle result pulse for core N
//   rsp_sum, rsp_cout, rsp_ovf       shared result, held until the next result
//   busy                             an operation is in RUN or DONE
module byte_adder_sched #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_ovf,
   output logic             busy
);
   localparam int NB = WIDTH / 8;
   localparam int KW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NB - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state;
   logic                last_grant;
   logic                owner;
   logic                carry;
   logic [KW-1:0]       k;
   logic [NB-1:0][7:0]  opa;
   logic [NB-1:0][7:0]  opb;
   logic [NB-1:0][7:0]  res;
   logic [NB-1:0][7:0]  res_nxt;
   logic [WIDTH-1:0]    sum_q;
   logic                cout_q;
   logic                ovf_q;

   logic accept, grant, hs;

   // ---------------- arbitration / handshake ----------------
   assign accept = ((state == S_IDLE) || (state == S_DONE)) && !rst;
   // Core 1 wins if it is alone, or if both are valid and core 0 went last.
   assign grant  = req1_valid && (!req0_valid || !last_grant);

   assign req0_ready = accept && !grant;
   assign req1_ready = accept &&  grant;
   assign hs = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   // ---------------- 8-bit prefix slice (Kogge-Stone) ----------------
   logic [7:0] sa, sb, ss;
   logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
   logic       sc;

   assign sa = opa[k];
   assign sb = opb[k];

   always_comb begin
      g0 = sa & sb;
      p0 = sa ^ sb;
      g1 = g0;
      p1 = p0;
      for (int i = 1; i < 8; i++) begin
         g1[i] = g0[i] | (p0[i] & g0[i-1]);
         p1[i] = p0[i] & p0[i-1];
      end
      g2 = g1;
      p2 = p1;
      for (int i = 2; i < 8; i++) begin
         g2[i] = g1[i] | (p1[i] & g1[i-2]);
         p2[i] = p1[i] & p1[i-2];
      end
      g3 = g2;
      p3 = p2;
      for (int i = 4; i < 8; i++) begin
         g3[i] = g2[i] | (p2[i] & g2[i-4]);
         p3[i] = p2[i] & p2[i-4];
      end
      // g3/p3[i] now span bits i..0; fold in the chained carry-in.
      ss    = '0;
      ss[0] = p0[0] ^ carry;
      for (int i = 1; i < 8; i++)
         ss[i] = p0[i] ^ (g3[i-1] | (p3[i-1] & carry));
      sc = g3[7] | (p3[7] & carry);
   end

   always_comb begin
      res_nxt    = res;
      res_nxt[k] = ss;
   end

   // ---------------- state ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         carry      <= 1'b0;
         k          <= '0;
         opa        <= '0;
         opb        <= '0;
         res        <= '0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else if (hs) begin
         // Subtract is A + ~B + 1: invert B here, carry-in supplies the +1.
         opa        <= grant ? req1_a : req0_a;
         opb        <= grant ? (req1_sub ? ~req1_b : req1_b)
                             : (req0_sub ? ~req0_b : req0_b);
         carry      <= grant ? req1_sub : req0_sub;
         owner      <= grant;
         last_grant <= grant;
         k          <= '0;
         state      <= S_RUN;
      end else begin
         case (state)
            S_RUN: begin
               res   <= res_nxt;
               carry <= sc;
               k     <= k + 1'b1;
               if (k == KLAST) begin
                  // Publish on the last pass so outputs are valid in DONE and
                  // stay put while the next operation runs.
                  state  <= S_DONE;
                  sum_q  <= res_nxt;
                  cout_q <= sc;
                  ovf_q  <= (opa[NB-1][7] == opb[NB-1][7]) &&
                            (ss[7] != opa[NB-1][7]);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------- outputs ----------------
   assign rsp0_valid = (state == S_DONE) && !owner && !rst;
   assign rsp1_valid = (state == S_DONE) &&  owner && !rst;
   assign rsp_sum    = sum_q;
   assign rsp_cout   = cout_q;
   assign rsp_ovf    = ovf_q;
   assign busy       = (state == S_RUN) || (state == S_DONE);

endmodule

// File: tb/tb_byte_adder_sched.sv
// Directed bench for byte_adder_sched (WIDTH = 32). Inputs are driven and
// outputs sampled just after the falling edge.
module tb_byte_adder_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_sub;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready, req1_sub;
   logic [31:0] req1_a, req1_b;
   logic        rsp0_valid, rsp1_valid, rsp_cout, rsp_ovf, busy;
   logic [31:0] rsp_sum;

   int n_cmp = 0;
   int n_bad = 0;

   byte_adder_sched #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        core;
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic core, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic sub);
      if (core) begin
         req1_valid = v; req1_a = a; req1_b = b; req1_sub = sub;
      end else begin
         req0_valid = v; req0_a = a; req0_b = b; req0_sub = sub;
      end
      #1;
   endtask

   task automatic chk_pulse(input string name, input logic core, input logic [31:0] sum,
                            input logic cout, input logic ovf);
      chk({name, "_rsp0"}, {31'd0, rsp0_valid}, {31'd0, !core});
      chk({name, "_rsp1"}, {31'd0, rsp1_valid}, {31'd0, core});
      chk({name, "_sum"},  rsp_sum, sum);
      chk({name, "_cout"}, {31'd0, rsp_cout}, {31'd0, cout});
      chk({name, "_ovf"},  {31'd0, rsp_ovf},  {31'd0, ovf});
   endtask

   // One isolated operation starting from IDLE; ends one cycle after DONE.
   task automatic run_vec(input string name, input vec_t v);
      drive(v.core, 1'b1, v.a, v.b, v.sub);
      chk({name, "_ready"}, {31'd0, (v.core ? req1_ready : req0_ready)}, 32'd1);
      step();
      drive(v.core, 1'b0, 32'd0, 32'd0, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         chk({name, "_run_norsp"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
         chk({name, "_busy"}, {31'd0, busy}, 32'd1);
         if (c < 4) step();
      end
      step();
      chk_pulse(name, v.core, v.sum, v.cout, v.ovf);
      step();
      chk({name, "_idle"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
   endtask

   vec_t vt[8];

   initial begin
      vt[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
      vt[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vt[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vt[3] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vt[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vt[5] = '{1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
      vt[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vt[7] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

      rst = 1'b1;
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_sub = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_sub = 0;
      step();
      step();

      // ---- reset state, requests held off while rst is high ----
      drive(1'b0, 1'b1, 32'h11111111, 32'h22222222, 1'b0);
      drive(1'b1, 1'b1, 32'h0000000A, 32'h00000003, 1'b1);
      chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("rst_rsp",   {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_sum",   rsp_sum, 32'd0);
      chk("rst_flags", {30'd0, rsp_cout, rsp_ovf}, 32'd0);
      step();

      // ---- both valid from reset release: grants 0,1,0,1 ----
      rst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         logic c;
         c = i[0];
         if (i > 0) begin
            if (c) chk_pulse("rr_rsp", 1'b0, 32'h33333333, 1'b0, 1'b0);
            else   chk_pulse("rr_rsp", 1'b1, 32'h00000007, 1'b1, 1'b0);
         end
         chk("rr_grant", {30'd0, req1_ready, req0_ready}, c ? 32'd2 : 32'd1);
         for (int j = 1; j <= 4; j++) begin
            step();
            chk("rr_run", {28'd0, req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 32'd0);
         end
         step();
      end
      // last op (core 1) in DONE; drop valids before the edge
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk_pulse("rr_last", 1'b1, 32'h00000007, 1'b1, 1'b0);
      step();
      chk("rr_idle_busy", {31'd0, busy}, 32'd0);

      // ---- table-driven single operations ----
      for (int i = 0; i < 8; i++)
         run_vec($sformatf("vec%0d", i), vt[i]);

      // ---- reset pulse while k=2 of a core 0 op ----
      drive(1'b0, 1'b1, 32'hDEAD0000, 32'h0000BEEF, 1'b0);
      chk("mr_ready", {31'd0, req0_ready}, 32'd1);
      step();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      step();
      step();
      rst = 1'b1;
      #1;
      chk("mr_rst_cycle_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      step();
      rst = 1'b0;
      #1;
      chk("mr_busy_after", {31'd0, busy}, 32'd0);
      begin
         logic seen;
         seen = 1'b0;
         for (int j = 0; j < 8; j++) begin
            if (rsp0_valid || rsp1_valid) seen = 1'b1;
            step();
         end
         chk("mr_no_rsp", {31'd0, seen}, 32'd0);
      end
      run_vec("mr_next", '{1'b0, 32'h0000_1000, 32'h0000_0234, 1'b0, 32'h0000_1234, 1'b0, 1'b0});

      // ---- back-to-back: core 1 accepted in core 0's DONE cycle ----
      drive(1'b0, 1'b1, 32'h0000_00F0, 32'h0000_0010, 1'b0);
      chk("bb_ready0", {31'd0, req0_ready}, 32'd1);
      step();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
      step(); step(); step();
      step();
      drive(1'b1, 1'b1, 32'h0000_0064, 32'h0000_0014, 1'b1);
      chk("bb_done_ready1", {31'd0, req1_ready}, 32'd1);
      chk_pulse("bb_rsp0", 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      step();
      drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
      for (int j = 1; j <= 4; j++) begin
         chk("bb_hold_sum", rsp_sum, 32'h0000_0100);
         chk("bb_gap_norsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
         step();
      end
      chk_pulse("bb_rsp1", 1'b1, 32'h0000_0050, 1'b1, 1'b0);
      step();
      chk("bb_idle", {31'd0, busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
